// File: rtl/fifo_word_serializer_pkg.sv
// Shared defaults and state encoding for the FIFO word serializer.
// Also used by the word FIFO so both sides agree on word and slice widths.
package fifo_word_serializer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W  = 8;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } ser_state_t;

  // A 1-slice word still needs a 1-bit counter.
  function automatic int slice_cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Drains a first-word-fall-through FIFO and emits each word as OUT_W-wide
// slices on a valid/ready stream, flagging the last slice of every word.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_EMPTY  | no word held; pops as soon as the FIFO is non-empty
// ST_ACTIVE | word held in the shift register; out_valid asserted
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int NSLICE = DATA_W / OUT_W;
  localparam int CNT_W  = slice_cnt_w(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_shifted;
  logic              accept;

  assign out_valid = (state == ST_ACTIVE);
  assign busy      = out_valid;
  assign accept    = out_valid && out_ready;
  assign out_last  = (state == ST_ACTIVE) && (cnt == LAST_CNT);

  // Pop whenever idle, or when the last slice leaves, so reloads are bubble-free.
  assign fifo_rd = !reset && !fifo_empty &&
                   ((state == ST_EMPTY) || (accept && out_last));

  generate
    if (MSB_FIRST) begin : g_msb
      assign out_data     = sreg[DATA_W-1 -: OUT_W];
      assign sreg_shifted = sreg << OUT_W;
    end else begin : g_lsb
      assign out_data     = sreg[OUT_W-1:0];
      assign sreg_shifted = sreg >> OUT_W;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (fifo_rd) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (accept && out_last) state_nxt = fifo_rd ? ST_ACTIVE : ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_rd) begin
        sreg <= fifo_rd_data;
        cnt  <= '0;
      end else if (accept) begin
        sreg <= sreg_shifted;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) fed from
// queue-modelled FIFOs, with hand-computed slice sequences.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;

  logic        fifo_empty_a, fifo_empty_b;
  logic [31:0] fifo_rd_data_a, fifo_rd_data_b;
  logic        fifo_rd_a, fifo_rd_b;
  logic [7:0]  out_data_a, out_data_b;
  logic        out_valid_a, out_valid_b;
  logic        out_last_a, out_last_b;
  logic        busy_a, busy_b;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty_a), .fifo_rd_data(fifo_rd_data_a),
    .fifo_rd(fifo_rd_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_last(out_last_a), .busy(busy_a)
  );

  fifo_word_serializer #(.DATA_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty_b), .fifo_rd_data(fifo_rd_data_b),
    .fifo_rd(fifo_rd_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_last(out_last_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty_a   = (q_a.size() == 0);
    fifo_rd_data_a = (q_a.size() != 0) ? q_a[0] : 32'h0;
    fifo_empty_b   = (q_b.size() == 0);
    fifo_rd_data_b = (q_b.size() != 0) ? q_b[0] : 32'h0;
  endtask

  // Pops are decided from fifo_rd sampled mid-cycle, applied just after the edge.
  task automatic step();
    logic rd_a, rd_b;
    #1;
    rd_a = fifo_rd_a;
    rd_b = fifo_rd_b;
    @(posedge clk);
    #1;
    if (rd_a && q_a.size() != 0) void'(q_a.pop_front());
    if (rd_b && q_b.size() != 0) void'(q_b.pop_front());
    refresh();
    #2;
  endtask

  logic [7:0] exp_dat[4];
  logic       exp_lst[4];
  int         rd_cnt;

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    refresh();
    step();
    step();

    // reset state
    #1;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_last",  out_last_a,  0);
    chk("rst_data",  out_data_a,  0);
    chk("rst_busy",  busy_a,      0);
    chk("rst_rd",    fifo_rd_a,   0);
    reset = 1'b0;

    // 1: empty FIFO, ready high, nothing happens
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t1_rd",    fifo_rd_a,   0);
      chk("t1_valid", out_valid_a, 0);
      step();
    end

    // 2: single word deadbeef
    q_a.push_back(32'hdeadbeef);
    refresh();
    #1;
    chk("t2_pop", fifo_rd_a, 1);
    chk("t2_pre_valid", out_valid_a, 0);
    step();
    exp_dat = '{8'hde, 8'had, 8'hbe, 8'hef};
    exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1};
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_valid", out_valid_a, 1);
      chk("t2_data",  out_data_a,  exp_dat[i]);
      chk("t2_last",  out_last_a,  exp_lst[i]);
      if (fifo_rd_a) rd_cnt++;
      step();
    end
    chk("t2_extra_pops", rd_cnt, 0);
    chk("t2_idle_valid", out_valid_a, 0);
    chk("t2_idle_busy",  busy_a, 0);

    // 3: back-to-back words, no bubble
    q_a.push_back(32'h00010203);
    q_a.push_back(32'h04050607);
    refresh();
    #1;
    chk("t3_pop0", fifo_rd_a, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_valid", out_valid_a, 1);
      chk("t3_data",  out_data_a,  i);
      chk("t3_last",  out_last_a,  (i % 4) == 3);
      chk("t3_rd",    fifo_rd_a,   i == 3);
      step();
    end
    chk("t3_idle_valid", out_valid_a, 0);

    // 4: backpressure holds slice 34
    q_a.push_back(32'h12345678);
    refresh();
    step();
    #1;
    chk("t4_first", out_data_a, 8'h12);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_data",  out_data_a,  8'h34);
      chk("t4_hold_valid", out_valid_a, 1);
      chk("t4_hold_last",  out_last_a,  0);
      chk("t4_hold_rd",    fifo_rd_a,   0);
      step();
    end
    out_ready = 1'b1;
    exp_dat = '{8'h34, 8'h56, 8'h78, 8'h00};
    exp_lst = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_data", out_data_a, exp_dat[i]);
      chk("t4_last", out_last_a, exp_lst[i]);
      step();
    end
    chk("t4_idle_valid", out_valid_a, 0);

    // 5: reset while slice ad is presented
    q_a.push_back(32'hdeadbeef);
    refresh();
    step();
    step();
    #1;
    chk("t5_pre_data", out_data_a, 8'had);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t5_valid", out_valid_a, 0);
    chk("t5_data",  out_data_a,  0);
    chk("t5_last",  out_last_a,  0);
    chk("t5_cnt",   dut_a.cnt,   0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_idle_valid", out_valid_a, 0);
      chk("t5_idle_rd",    fifo_rd_a,   0);
      step();
    end

    // no pop during reset; drain restarts from head afterwards
    q_a.push_back(32'ha1b2c3d4);
    refresh();
    reset = 1'b1;
    #1;
    chk("t5_rst_rd", fifo_rd_a, 0);
    step();
    chk("t5_rst_qsize", q_a.size(), 1);
    reset = 1'b0;
    #1;
    chk("t5_rel_rd", fifo_rd_a, 1);
    step();
    exp_dat = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
    exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_data", out_data_a, exp_dat[i]);
      chk("t5_last", out_last_a, exp_lst[i]);
      step();
    end
    chk("t5_end_valid", out_valid_a, 0);

    // 6: LSB-first instance
    q_b.push_back(32'hdeadbeef);
    refresh();
    #1;
    chk("t6_pop", fifo_rd_b, 1);
    step();
    exp_dat = '{8'hef, 8'hbe, 8'had, 8'hde};
    exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_valid", out_valid_b, 1);
      chk("t6_data",  out_data_b,  exp_dat[i]);
      chk("t6_last",  out_last_b,  exp_lst[i]);
      step();
    end
    chk("t6_idle_valid", out_valid_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
